// File: rtl/eggtimer_pkg.sv
// Shared types, default constants and the mod-60 BCD step used by the egg-timer front end.
package eggtimer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_pair_t;

  localparam int SEC_MAX_DEF    = 999;
  localparam int DISP_MAX_DEF   = 1;
  localparam int DBNC_MAX_DEF   = 9;
  localparam int DBNC_DEPTH_DEF = 2;
  localparam int CTR_WIDTH_DEF  = 12;

  localparam bcd_digit_t BCD_ONES_MAX = 4'd9;
  localparam bcd_digit_t BCD_TENS_MAX = 4'd5;

  // 59 rolls straight to 00 rather than passing through an illegal 60.
  function automatic bcd_pair_t bcd_inc60(input bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.ones == BCD_ONES_MAX) begin
      r.ones = '0;
      r.tens = (v.tens == BCD_TENS_MAX) ? '0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a strobe-advanced sample shift register;
// the level only moves once every held sample agrees.
module button_debounce
  import eggtimer_pkg::*;
#(
  parameter int DEPTH = DBNC_DEPTH_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sample_i,
  input  logic btn_i,
  output logic level_o
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;
  logic [DEPTH-1:0] shifted;
  logic             level_q;
  logic             level_d;

  if (DEPTH > 1) begin : g_multi
    assign shifted = {shift_q[DEPTH-2:0], sync_q[1]};
  end else begin : g_single
    assign shifted = sync_q[1];
  end

  always_comb begin
    shift_d = shift_q;
    level_d = level_q;
    if (sample_i) begin
      shift_d = shifted;
      if (&shifted) begin
        level_d = 1'b1;
      end else if (~|shifted) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      shift_q <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      shift_q <= shift_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/cooktime_input_frontend.sv
// Egg-timer input front end: strobe dividers, three debounced buttons and the
// programmed mm:ss cook time held as two independent BCD mod-60 counters.
module cooktime_input_frontend
  import eggtimer_pkg::*;
#(
  parameter int SEC_MAX    = SEC_MAX_DEF,
  parameter int DISP_MAX   = DISP_MAX_DEF,
  parameter int DBNC_MAX   = DBNC_MAX_DEF,
  parameter int DBNC_DEPTH = DBNC_DEPTH_DEF,
  parameter int CTR_WIDTH  = CTR_WIDTH_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cooktime_btn_i,
  input  logic       minutes_btn_i,
  input  logic       seconds_btn_i,
  input  logic       prog_mode_i,
  output logic       pulse_1s_o,
  output logic       pulse_disp_o,
  output logic       cooktime_req_o,
  output logic       minutes_dbnce_o,
  output logic       seconds_dbnce_o,
  output bcd_digit_t seconds_prog_o,
  output bcd_digit_t tens_seconds_prog_o,
  output bcd_digit_t minutes_prog_o,
  output bcd_digit_t tens_minutes_prog_o
);

  localparam int NUM_DIV = 3;
  localparam logic [NUM_DIV-1:0][CTR_WIDTH-1:0] DIV_MAX = {
    CTR_WIDTH'(DBNC_MAX), CTR_WIDTH'(DISP_MAX), CTR_WIDTH'(SEC_MAX)
  };

  logic [NUM_DIV-1:0] tick;

  // Index 0: 1 s, index 1: display refresh, index 2: debounce sampling.
  for (genvar g = 0; g < NUM_DIV; g++) begin : g_div
    logic [CTR_WIDTH-1:0] cnt_q;
    logic [CTR_WIDTH-1:0] cnt_d;

    always_comb begin
      cnt_d = (cnt_q == DIV_MAX[g]) ? '0 : cnt_q + CTR_WIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign tick[g] = (cnt_q == DIV_MAX[g]);
  end

  logic cooktime_lvl;
  logic minutes_lvl;
  logic seconds_lvl;

  button_debounce #(.DEPTH(DBNC_DEPTH)) u_dbnc_cooktime (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sample_i (tick[2]),
    .btn_i    (cooktime_btn_i),
    .level_o  (cooktime_lvl)
  );

  button_debounce #(.DEPTH(DBNC_DEPTH)) u_dbnc_minutes (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sample_i (tick[2]),
    .btn_i    (minutes_btn_i),
    .level_o  (minutes_lvl)
  );

  button_debounce #(.DEPTH(DBNC_DEPTH)) u_dbnc_seconds (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sample_i (tick[2]),
    .btn_i    (seconds_btn_i),
    .level_o  (seconds_lvl)
  );

  logic      sec_prev_q;
  logic      min_prev_q;
  logic      inc_sec;
  logic      inc_min;
  bcd_pair_t sec_q;
  bcd_pair_t sec_d;
  bcd_pair_t min_q;
  bcd_pair_t min_d;

  // An edge seen while not armed is dropped; a held button cannot re-fire.
  assign inc_sec = seconds_lvl & ~sec_prev_q & cooktime_lvl & prog_mode_i;
  assign inc_min = minutes_lvl & ~min_prev_q & cooktime_lvl & prog_mode_i;

  always_comb begin
    sec_d = inc_sec ? bcd_inc60(sec_q) : sec_q;
    min_d = inc_min ? bcd_inc60(min_q) : min_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sec_prev_q <= 1'b0;
      min_prev_q <= 1'b0;
      sec_q      <= '0;
      min_q      <= '0;
    end else begin
      sec_prev_q <= seconds_lvl;
      min_prev_q <= minutes_lvl;
      sec_q      <= sec_d;
      min_q      <= min_d;
    end
  end

  assign pulse_1s_o          = tick[0];
  assign pulse_disp_o        = tick[1];
  assign cooktime_req_o      = cooktime_lvl;
  assign minutes_dbnce_o     = minutes_lvl;
  assign seconds_dbnce_o     = seconds_lvl;
  assign seconds_prog_o      = sec_q.ones;
  assign tens_seconds_prog_o = sec_q.tens;
  assign minutes_prog_o      = min_q.ones;
  assign tens_minutes_prog_o = min_q.tens;

endmodule

// File: tb/tb_cooktime_input_frontend.sv
// Bench for the egg-timer input front end: the programmed time is predicted from
// counts of accepted presses, reduced mod 60 and split into BCD digits.
module tb_cooktime_input_frontend;
  import eggtimer_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cooktimeBtn;
  logic       minutesBtn;
  logic       secondsBtn;
  logic       progMode;
  logic       pulse1s;
  logic       pulseDisp;
  logic       cooktimeReq;
  logic       minutesDbnce;
  logic       secondsDbnce;
  bcd_digit_t secondsProg;
  bcd_digit_t tensSecondsProg;
  bcd_digit_t minutesProg;
  bcd_digit_t tensMinutesProg;

  int checks = 0;
  int errors = 0;
  int secCount = 0;
  int minCount = 0;
  int latency;
  int needSec;
  int needMin;
  logic sawHigh;

  always #5 clk = ~clk;

  cooktime_input_frontend dut (
    .clk_i               (clk),
    .rst_ni              (rstN),
    .cooktime_btn_i      (cooktimeBtn),
    .minutes_btn_i       (minutesBtn),
    .seconds_btn_i       (secondsBtn),
    .prog_mode_i         (progMode),
    .pulse_1s_o          (pulse1s),
    .pulse_disp_o        (pulseDisp),
    .cooktime_req_o      (cooktimeReq),
    .minutes_dbnce_o     (minutesDbnce),
    .seconds_dbnce_o     (secondsDbnce),
    .seconds_prog_o      (secondsProg),
    .tens_seconds_prog_o (tensSecondsProg),
    .minutes_prog_o      (minutesProg),
    .tens_minutes_prog_o (tensMinutesProg)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Expected digits come straight from the number of accepted presses.
  task automatic checkTime(input string tag);
    checkOutput({tag, "_secOnes"}, 32'(secondsProg), 32'(secCount % 10));
    checkOutput({tag, "_secTens"}, 32'(tensSecondsProg), 32'((secCount % 60) / 10));
    checkOutput({tag, "_minOnes"}, 32'(minutesProg), 32'(minCount % 10));
    checkOutput({tag, "_minTens"}, 32'(tensMinutesProg), 32'((minCount % 60) / 10));
  endtask

  // Changes the arming inputs and waits long enough for cooktime to settle.
  task automatic setMode(input logic cook, input logic prog);
    cooktimeBtn = cook;
    progMode = prog;
    repeat (30) @(negedge clk);
    checkOutput("cooktime_req_settled", 32'(cooktimeReq), 32'(cook));
  endtask

  task automatic applyStimulus(input logic pressSec, input logic pressMin, input int hold, input int gap);
    logic qualify;
    qualify = cooktimeBtn && progMode;
    secondsBtn = pressSec;
    minutesBtn = pressMin;
    repeat (hold) @(negedge clk);
    if (hold >= 25) begin
      if (pressSec) checkOutput("sec_dbnce_held", 32'(secondsDbnce), 32'd1);
      if (pressMin) checkOutput("min_dbnce_held", 32'(minutesDbnce), 32'd1);
    end
    secondsBtn = 1'b0;
    minutesBtn = 1'b0;
    repeat (gap) @(negedge clk);
    if (qualify) begin
      if (pressSec) secCount++;
      if (pressMin) minCount++;
    end
    checkOutput("sec_dbnce_released", 32'(secondsDbnce), 32'd0);
    checkOutput("min_dbnce_released", 32'(minutesDbnce), 32'd0);
    checkTime("press");
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    cooktimeBtn = 1'b0;
    minutesBtn = 1'b0;
    secondsBtn = 1'b0;
    progMode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pulse1s", 32'(pulse1s), 32'd0);
    checkOutput("rst_pulseDisp", 32'(pulseDisp), 32'd0);
    checkOutput("rst_cooktimeReq", 32'(cooktimeReq), 32'd0);
    checkOutput("rst_minutesDbnce", 32'(minutesDbnce), 32'd0);
    checkOutput("rst_secondsDbnce", 32'(secondsDbnce), 32'd0);
    checkTime("rst");

    // Strobes: k edges after release, 1 s fires when k%1000==999, display on odd k.
    rstN = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      checkOutput("pulse_1s", 32'(pulse1s), 32'((k % 1000) == 999));
      checkOutput("pulse_disp", 32'(pulseDisp), 32'((k % 2) == 1));
    end

    $display("[TB] first armed seconds press, latency and one-clk update delay");
    setMode(1'b1, 1'b1);
    latency = 0;
    secondsBtn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (secondsDbnce === 1'b1) begin
        latency = i;
        break;
      end
    end
    checkOutput("sec_rise_seen", 32'(latency != 0), 32'd1);
    checkOutput("sec_rise_within_22", 32'(latency >= 2 && latency <= 22), 32'd1);
    checkOutput("sec_prog_at_edge", 32'(secondsProg), 32'd0);
    @(negedge clk);
    checkOutput("sec_prog_after_edge", 32'(secondsProg), 32'd1);
    secCount = 1;
    repeat (10) @(negedge clk);
    secondsBtn = 1'b0;
    repeat (30) @(negedge clk);
    checkTime("first_press");

    $display("[TB] unarmed minutes presses");
    setMode(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 20, 30);
    setMode(1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1, 20, 30);
    checkTime("unarmed");

    $display("[TB] short glitch on minutes");
    setMode(1'b1, 1'b1);
    sawHigh = 1'b0;
    minutesBtn = 1'b1;
    repeat (5) @(negedge clk);
    minutesBtn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (minutesDbnce !== 1'b0) sawHigh = 1'b1;
    end
    checkOutput("glitch_rejected", 32'(sawHigh), 32'd0);
    checkTime("glitch");

    $display("[TB] sixty seconds presses through carry and wrap");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'b0, 25 + int'($urandom_range(0, 5)), 30);
    end

    $display("[TB] randomized arming and button mix");
    for (int r = 0; r < 20; r++) begin
      setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int p = 0; p < 2; p++) begin
        int sel;
        sel = int'($urandom_range(1, 3));
        applyStimulus(sel[0], sel[1], int'($urandom_range(25, 40)), int'($urandom_range(25, 40)));
      end
    end

    $display("[TB] program 12:34 then reset asynchronously");
    setMode(1'b1, 1'b1);
    needSec = (34 - (secCount % 60) + 60) % 60;
    needMin = (12 - (minCount % 60) + 60) % 60;
    while (needSec > 0 || needMin > 0) begin
      applyStimulus(needSec > 0, needMin > 0, 26, 26);
      if (needSec > 0) needSec--;
      if (needMin > 0) needMin--;
    end
    checkOutput("prog_1234_minTens", 32'(tensMinutesProg), 32'd1);
    checkOutput("prog_1234_minOnes", 32'(minutesProg), 32'd2);
    checkOutput("prog_1234_secTens", 32'(tensSecondsProg), 32'd3);
    checkOutput("prog_1234_secOnes", 32'(secondsProg), 32'd4);

    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    secCount = 0;
    minCount = 0;
    checkOutput("async_pulse1s", 32'(pulse1s), 32'd0);
    checkOutput("async_pulseDisp", 32'(pulseDisp), 32'd0);
    checkOutput("async_cooktimeReq", 32'(cooktimeReq), 32'd0);
    checkOutput("async_minutesDbnce", 32'(minutesDbnce), 32'd0);
    checkOutput("async_secondsDbnce", 32'(secondsDbnce), 32'd0);
    checkTime("async_rst");
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("post_rst_cooktimeReq", 32'(cooktimeReq), 32'd1);
    applyStimulus(1'b1, 1'b0, 30, 30);
    applyStimulus(1'b0, 1'b1, 30, 30);
    checkOutput("post_rst_secOnes", 32'(secondsProg), 32'd1);
    checkOutput("post_rst_minOnes", 32'(minutesProg), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
